// File: rtl/init_longpress_detector_if.sv
// Button-to-sequencer signal bundle: raw button level in, one-cycle init pulse out.
interface init_longpress_detector_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/init_longpress_detector.sv
// Synchronises and debounces a raw push-button, then emits a single one-cycle
// init pulse once the debounced level has been held high for HOLD_CYCLES.
module init_longpress_detector #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  init_longpress_detector_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] STAB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(HOLD_CYCLES);

  logic                 s1;
  logic                 s;
  logic                 db;
  logic                 fired;
  logic                 out_q;
  logic [CNT_WIDTH-1:0] stab_cnt;
  logic [CNT_WIDTH-1:0] hold_cnt;

  // NOTE: every flop clears on the asynchronous reset and all state uses <=,
  // so each block sees the previous cycle's values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= bus.in;
      s  <= s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db       <= 1'b0;
      stab_cnt <= '0;
    end else if (s != db) begin
      if (stab_cnt == STAB_LAST) begin
        db       <= s;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end else begin
      stab_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!db) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Fire does not look at db: a press whose debounced high lasts exactly
  // HOLD_CYCLES still fires on the edge where db has already dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      fired <= 1'b0;
    end else if (hold_cnt == HOLD_MAX && !fired) begin
      out_q <= 1'b1;
      fired <= 1'b1;
    end else begin
      out_q <= 1'b0;
      if (!db) fired <= 1'b0;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_init_longpress_detector.sv
// Randomised and directed bench for init_longpress_detector against a
// timestamp-based reference model of debounce edges and press duration.
module tb_init_longpress_detector;

  localparam int D = 4;
  localparam int H = 20;
  localparam int W = 8;
  localparam int LAT = 2 + D + H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  init_longpress_detector_if bus ();

  init_longpress_detector #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .CNT_WIDTH      (W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Model: input samples per edge since reset, debounced level, and the edge
  // numbers of the last debounced rise and fall.
  logic hist[$];
  logic m_db;
  int   rise_e;
  int   fall_e;

  int edge_no;
  int win_pulses;
  int first_pulse_edge;

  function automatic logic s_at(input int j);
    if (j < 2) return 1'b0;
    return hist[j-2];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_db   = 1'b0;
    rise_e = -1000000;
    fall_e = -1000000;
  endtask

  // A press fires H+1 edges after its debounced rise, provided the debounced
  // level stayed high for at least H edges.
  task automatic model_edge(output logic exp);
    int   k;
    logic stable;
    k = hist.size();
    hist.push_back(bus.in);
    exp = (k == rise_e + H + 1) && (fall_e < rise_e || fall_e >= rise_e + H);
    stable = 1'b1;
    for (int j = k - D + 1; j <= k; j++)
      if (s_at(j) !== ~m_db) stable = 1'b0;
    if (stable) begin
      m_db = ~m_db;
      if (m_db) rise_e = k;
      else      fall_e = k;
    end
  endtask

  task automatic start_window();
    edge_no          = 0;
    win_pulses       = 0;
    first_pulse_edge = -1;
  endtask

  task automatic cycle(input logic v);
    logic e;
    bus.in = v;
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
    check("out", bus.out, e);
    if (bus.out === 1'b1) begin
      win_pulses++;
      if (first_pulse_edge < 0) first_pulse_edge = edge_no;
    end
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic press(input int len, input int exp_pulses, input string tag);
    idle(12);
    start_window();
    for (int i = 0; i < len; i++) cycle(1'b1);
    idle(12);
    check(tag, win_pulses, exp_pulses);
  endtask

  int lengths[4] = '{10, 15, 19, 12};

  initial begin
    bus.in = 1'b0;
    model_reset();
    start_window();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in = 1'($urandom_range(0, 1));
      #1 check("out_in_reset", bus.out, 0);
    end
    bus.in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start_window();
    idle(100);
    check("idle_pulses", win_pulses, 0);

    foreach (lengths[i]) press(lengths[i], 0, "short_press");

    press(H, 1, "threshold_exact");
    press(H - 1, 0, "threshold_minus1");

    idle(12);
    start_window();
    for (int i = 0; i < 120; i++) cycle(1'b1);
    check("long_press_pulses", win_pulses, 1);
    check("long_press_latency", first_pulse_edge, LAT);
    idle(12);

    idle(12);
    start_window();
    for (int i = 0; i < 60; i++) cycle((i % 10) < 7);
    check("bounce3_pulses", win_pulses, 1);
    check("bounce3_latency", first_pulse_edge, LAT);
    idle(12);

    idle(12);
    start_window();
    for (int i = 0; i < 60; i++) cycle((i % 10) < 6);
    idle(12);
    check("bounce4_pulses", win_pulses, 0);

    idle(12);
    start_window();
    for (int i = 0; i < 2 + D + 15; i++) cycle(1'b1);
    rst_n = 1'b0;
    #1 check("out_reset_assert", bus.out, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("out_reset_hold", bus.out, 0);
    end
    rst_n = 1'b1;
    model_reset();
    start_window();
    for (int i = 0; i < 60; i++) cycle(1'b1);
    check("reset_press_pulses", win_pulses, 1);
    check("reset_press_latency", first_pulse_edge, LAT);
    idle(12);

    start_window();
    for (int seg = 0; seg < 300; seg++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = (seg % 5 == 0) ? int'($urandom_range(18, 40)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) cycle(v);
    end
    idle(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
